// File: rtl/conv_pkg.sv
// Shared types and helpers for the conv output requantiser.
// Holds the FSM state enum, the slice limit and the slice-count rule.
package conv_pkg;

    localparam int unsigned MAX_SLICES = 4;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        CALC,
        EMIT
    } state_e;

    // Effective 2-bit slice count: act_bits[7:1] clamped to 1..MAX_SLICES.
    function automatic logic [2:0] num_slices(input logic [7:0] act_bits);
        logic [6:0] half;
        half = act_bits[7:1];
        if (half == 7'd0) begin
            return 3'd1;
        end else if (half >= 7'(MAX_SLICES)) begin
            return 3'(MAX_SLICES);
        end else begin
            return half[2:0];
        end
    endfunction

endpackage

// File: rtl/requant_lane.sv
// Combinational datapath for one output lane: bias add, rounded arithmetic
// right shift, ReLU/signed clamp to 2*ns bits and a saturation flag.
module requant_lane
    import conv_pkg::*;
#(
    parameter int unsigned ACC_W = 32
) (
    input  logic [ACC_W-1:0] acc_i,
    input  logic [ACC_W-1:0] bias_i,
    output logic [ACC_W:0]   y_o,
    input  logic [ACC_W:0]   y_i,
    input  logic [4:0]       shift_i,
    input  logic             relu_i,
    input  logic [2:0]       ns_i,
    output logic [7:0]       code_o,
    output logic             sat_o
);

    localparam int unsigned W2 = ACC_W + 2;
    localparam logic signed [W2-1:0] One = {{(W2-1){1'b0}}, 1'b1};

    logic signed [W2-1:0] y_ext;
    logic signed [W2-1:0] rnd;
    logic signed [W2-1:0] r;
    logic signed [W2-1:0] hi;
    logic signed [W2-1:0] lo;
    logic signed [W2-1:0] clamped;
    logic [3:0]           b;

    assign y_o = {acc_i[ACC_W-1], acc_i} + {bias_i[ACC_W-1], bias_i};

    always_comb begin
        b     = {ns_i, 1'b0};
        y_ext = {y_i[ACC_W], y_i};
        // One extra guard bit keeps the half-LSB rounding add from wrapping.
        rnd   = y_ext + ((shift_i != 5'd0) ? (One <<< (shift_i - 5'd1)) : '0);
        r     = rnd >>> shift_i;
        if (relu_i) begin
            hi = (One <<< b) - One;
            lo = '0;
        end else begin
            hi = (One <<< (b - 4'd1)) - One;
            lo = -(One <<< (b - 4'd1));
        end
        if (r > hi) begin
            clamped = hi;
        end else if (r < lo) begin
            clamped = lo;
        end else begin
            clamped = r;
        end
        sat_o  = (clamped != r);
        code_o = clamped[7:0];
    end

endmodule

// File: rtl/conv_out_requant.sv
// Output stage of the conv core: requantises one accumulator vector per
// handshake and streams each lane's code out as 2-bit slices, LSB first.
module conv_out_requant
    import conv_pkg::*;
#(
    parameter int unsigned OC2_LANES = 16,
    parameter int unsigned ACC_W     = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [7:0]                   cfg_act_bits,
    input  logic [4:0]                   cfg_shift,
    input  logic                         cfg_relu,
    input  logic [OC2_LANES*ACC_W-1:0]   bias_in,
    input  logic [OC2_LANES*ACC_W-1:0]   in_acc,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [OC2_LANES*2-1:0]       out_code,
    output logic [2:0]                   out_slice_sel,
    output logic                         out_last,
    output logic                         out_sat,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         busy
);

    state_e                             state_q;
    logic [2:0]                         ns_q;
    logic [4:0]                         shift_q;
    logic                               relu_q;
    logic [OC2_LANES*ACC_W-1:0]         acc_q;
    logic [OC2_LANES*ACC_W-1:0]         bias_q;
    logic [OC2_LANES-1:0][ACC_W:0]      y_q;
    logic [OC2_LANES-1:0][7:0]          code_q;
    logic                               sat_q;
    logic [2:0]                         cnt_q;

    logic [OC2_LANES-1:0][ACC_W:0]      y_d;
    logic [OC2_LANES-1:0][7:0]          code_d;
    logic [OC2_LANES-1:0]               sat_d;

    for (genvar l = 0; l < OC2_LANES; l++) begin : g_lane
        requant_lane #(
            .ACC_W (ACC_W)
        ) u_lane (
            .acc_i   (acc_q[l*ACC_W +: ACC_W]),
            .bias_i  (bias_q[l*ACC_W +: ACC_W]),
            .y_o     (y_d[l]),
            .y_i     (y_q[l]),
            .shift_i (shift_q),
            .relu_i  (relu_q),
            .ns_i    (ns_q),
            .code_o  (code_d[l]),
            .sat_o   (sat_d[l])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ns_q    <= 3'd1;
            shift_q <= '0;
            relu_q  <= 1'b0;
            acc_q   <= '0;
            bias_q  <= '0;
            y_q     <= '0;
            code_q  <= '0;
            sat_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        acc_q   <= in_acc;
                        bias_q  <= bias_in;
                        ns_q    <= num_slices(cfg_act_bits);
                        shift_q <= cfg_shift;
                        relu_q  <= cfg_relu;
                        state_q <= ADD;
                    end
                end
                ADD: begin
                    y_q     <= y_d;
                    state_q <= CALC;
                end
                CALC: begin
                    code_q  <= code_d;
                    sat_q   <= |sat_d;
                    cnt_q   <= '0;
                    state_q <= EMIT;
                end
                EMIT: begin
                    if (out_ready) begin
                        if (cnt_q == ns_q - 3'd1) begin
                            cnt_q   <= '0;
                            state_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + 3'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready      = (state_q == IDLE);
    assign out_valid     = (state_q == EMIT);
    assign busy          = (state_q != IDLE);
    assign out_last      = out_valid && (cnt_q == ns_q - 3'd1);
    assign out_slice_sel = cnt_q;
    assign out_sat       = sat_q;

    always_comb begin
        out_code = '0;
        for (int l = 0; l < OC2_LANES; l++) begin
            out_code[2*l +: 2] = code_q[l][{cnt_q[1:0], 1'b0} +: 2];
        end
    end

endmodule
